// File: rtl/ext_pipe.sv
`default_nettype none
// ext_pipe: two-stage valid/ready pipeline that zero/sign/upper/branch-extends an immediate.
// Rev 1.0
module ext_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  localparam int EXT_W = OUT_W - IN_W;

  localparam logic [2:0] MODE_ZERO   = 3'b000;
  localparam logic [2:0] MODE_SIGN   = 3'b001;
  localparam logic [2:0] MODE_UPPER  = 3'b010;
  localparam logic [2:0] MODE_BRANCH = 3'b011;

  logic             s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]  s1_data_q,  s1_data_d;
  logic [2:0]       s1_mode_q,  s1_mode_d;
  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] s2_data_q,  s2_data_d;
  logic             s2_err_q,   s2_err_d;

  logic             in_fire;
  logic             s1_adv;
  logic             out_fire;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_data;
  logic             ext_err;

  // S1 may refill in the same edge it drains into S2, hence the out_ready term.
  assign in_ready = !flush && (!s1_valid_q || !s2_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign out_fire = s2_valid_q && out_ready;

  assign sext = {{EXT_W{s1_data_q[IN_W-1]}}, s1_data_q};

  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (s1_mode_q)
      MODE_ZERO:   ext_data = {{EXT_W{1'b0}}, s1_data_q};
      MODE_SIGN:   ext_data = sext;
      MODE_UPPER:  ext_data = {s1_data_q, {EXT_W{1'b0}}};
      MODE_BRANCH: ext_data = sext << BR_SHIFT;
      default:     ext_err  = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_err_d   = s2_err_q;

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_adv) begin
        s2_valid_d = 1'b1;
        s2_data_d  = ext_data;
        s2_err_d   = ext_err;
      end else if (out_fire) begin
        s2_valid_d = 1'b0;
      end

      if (in_fire) begin
        s1_valid_d = 1'b1;
        s1_data_d  = in_data;
        s1_mode_d  = in_mode;
      end else if (s1_adv) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_err   = s2_err_q;

endmodule
`default_nettype wire
